// File: rtl/cpumc_arbiter.sv
// cpumc_arbiter: N-master arbiter for the shared CPU memory-controller bus.
// A registered one-hot grant selects which master's address, direction and
// write data reach cart/wram/ppu. Fixed-priority or round-robin selection,
// a bounded hold time that a master can override with its lock bit, and one
// mandatory idle cycle between successive owners.
module cpumc_arbiter #(
    parameter int NUM_MASTERS = 3,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int RR_MODE     = 0,
    parameter int MAX_HOLD    = 0
) (
    input  logic                          clk_in,
    input  logic                          nres_in,
    input  logic [NUM_MASTERS-1:0]        req_in,
    input  logic [NUM_MASTERS-1:0]        lock_in,
    input  logic [NUM_MASTERS*ADDR_W-1:0] a_in,
    input  logic [NUM_MASTERS-1:0]        r_nw_in,
    input  logic [NUM_MASTERS*DATA_W-1:0] d_in,
    output logic [NUM_MASTERS-1:0]        gnt_out,
    output logic [2:0]                    gnt_idx_out,
    output logic                          busy_out,
    output logic [ADDR_W-1:0]             a_out,
    output logic                          r_nw_out,
    output logic [DATA_W-1:0]             d_out
);

    localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0]      HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0]      HOLD_ONE = HOLD_W'(1);
    localparam logic [HOLD_W-1:0]      HOLD_ZERO = HOLD_W'(0);
    localparam logic [2:0]             LAST_RST = 3'(NUM_MASTERS - 1);
    localparam logic [NUM_MASTERS-1:0] GNT_ONE  = NUM_MASTERS'(1);
    localparam logic [NUM_MASTERS-1:0] GNT_NONE = NUM_MASTERS'(0);
    localparam bit                     HOLD_EN  = (MAX_HOLD > 0);
    localparam bit                     RR_EN    = (RR_MODE != 0);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
    logic [2:0]             idx_q, idx_d;
    logic [2:0]             last_q, last_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;

    logic [2:0]             win_s;
    logic [HOLD_W-1:0]      hold_inc_s;
    logic                   owner_req_s;
    logic                   owner_lock_s;
    logic                   others_req_s;
    logic                   expire_s;

    // Lowest requesting index wins.
    function automatic logic [2:0] pick_fixed(input logic [NUM_MASTERS-1:0] req);
        logic [2:0] pick;
        pick = 3'd0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (req[i]) pick = 3'(i);
        end
        return pick;
    endfunction

    // First requester searching upward from last+1, wrapping to index 0.
    function automatic logic [2:0] pick_rr(input logic [NUM_MASTERS-1:0] req,
                                           input logic [2:0]             last);
        logic [2:0] pick;
        logic       found;
        pick  = 3'd0;
        found = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!found && (3'(i) > last) && req[i]) begin
                pick  = 3'(i);
                found = 1'b1;
            end
        end
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!found && (3'(i) <= last) && req[i]) begin
                pick  = 3'(i);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Winner selection and hold-expiry qualification for the current owner.
    always_comb begin
        win_s        = RR_EN ? pick_rr(req_in, last_q) : pick_fixed(req_in);
        owner_req_s  = |(req_in & gnt_q);
        owner_lock_s = |(lock_in & gnt_q);
        others_req_s = |(req_in & ~gnt_q);
        hold_inc_s   = (hold_q == HOLD_MAX) ? hold_q : (hold_q + HOLD_ONE);
        expire_s     = HOLD_EN && (hold_inc_s == HOLD_MAX) && !owner_lock_s && others_req_s;
    end

    // Next-state logic: grant from IDLE, release or revoke from OWNED.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        last_d  = last_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_in) begin
                    state_d = ST_OWNED;
                    gnt_d   = GNT_ONE << win_s;
                    idx_d   = win_s;
                    last_d  = win_s;
                    hold_d  = HOLD_ZERO;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OWNED: begin
                // Release and expiry share one outcome: drop to IDLE for a cycle.
                if (!owner_req_s || expire_s) begin
                    state_d = ST_IDLE;
                    gnt_d   = GNT_NONE;
                    idx_d   = 3'd0;
                    hold_d  = HOLD_ZERO;
                end else begin
                    hold_d  = hold_inc_s;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = GNT_NONE;
                idx_d   = 3'd0;
                hold_d  = HOLD_ZERO;
            end
        endcase
    end

    // State, grant, owner index, round-robin pointer and hold counter registers.
    always_ff @(posedge clk_in or negedge nres_in) begin
        if (!nres_in) begin
            state_q <= ST_IDLE;
            gnt_q   <= GNT_NONE;
            idx_q   <= 3'd0;
            last_q  <= LAST_RST;
            hold_q  <= HOLD_ZERO;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    // Shared bus mux driven from the registered one-hot grant; idle bus reads address 0.
    always_comb begin
        a_out    = {ADDR_W{1'b0}};
        d_out    = {DATA_W{1'b0}};
        r_nw_out = &(~gnt_q | r_nw_in);
        for (int i = 0; i < NUM_MASTERS; i++) begin
            a_out = a_out | ({ADDR_W{gnt_q[i]}} & a_in[i*ADDR_W +: ADDR_W]);
            d_out = d_out | ({DATA_W{gnt_q[i]}} & d_in[i*DATA_W +: DATA_W]);
        end
    end

    assign gnt_out     = gnt_q;
    assign gnt_idx_out = idx_q;
    assign busy_out    = |gnt_q;

endmodule

// File: tb/tb_cpumc_arbiter.sv
// Bench for cpumc_arbiter: four instances (fixed/RR x unlimited/4-cycle hold)
// share one stimulus stream; a behavioural owner/last/held model predicts them.
module tb_cpumc_arbiter;

    localparam int N    = 3;
    localparam int AW   = 16;
    localparam int DW   = 8;
    localparam int NCFG = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            nres;
    logic [N-1:0]    req, lock, rnw;
    logic [N*AW-1:0] a;
    logic [N*DW-1:0] d;

    logic [N-1:0]  gnt_o  [NCFG];
    logic [2:0]    idx_o  [NCFG];
    logic          busy_o [NCFG];
    logic [AW-1:0] a_o    [NCFG];
    logic          rnw_o  [NCFG];
    logic [DW-1:0] d_o    [NCFG];

    // cfg k: RR_MODE = k%2, MAX_HOLD = (k/2)*4
    generate
        for (genvar k = 0; k < NCFG; k++) begin : g_dut
            cpumc_arbiter #(
                .NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW),
                .RR_MODE(k % 2), .MAX_HOLD((k / 2) * 4)
            ) u_dut (
                .clk_in(clk), .nres_in(nres), .req_in(req), .lock_in(lock),
                .a_in(a), .r_nw_in(rnw), .d_in(d),
                .gnt_out(gnt_o[k]), .gnt_idx_out(idx_o[k]), .busy_out(busy_o[k]),
                .a_out(a_o[k]), .r_nw_out(rnw_o[k]), .d_out(d_o[k])
            );
        end
    endgenerate

    int n_checks = 0;
    int n_pass   = 0;

    // Model: owner (-1 = idle), last granted index, cycles held so far.
    int m_owner [NCFG];
    int m_last  [NCFG];
    int m_held  [NCFG];

    task automatic model_reset();
        for (int k = 0; k < NCFG; k++) begin
            m_owner[k] = -1;
            m_last[k]  = N - 1;
            m_held[k]  = 0;
        end
    endtask

    task automatic model_step();
        int w, g, mh, c;
        if (!nres) begin
            model_reset();
            return;
        end
        for (int k = 0; k < NCFG; k++) begin
            mh = (k / 2) * 4;
            if (m_owner[k] < 0) begin
                if (req != 0) begin
                    w = -1;
                    if (k % 2 == 1) begin
                        for (int s = 1; s <= N; s++) begin
                            c = (m_last[k] + s) % N;
                            if (w < 0 && req[c]) w = c;
                        end
                    end else begin
                        for (int i = 0; i < N; i++) if (w < 0 && req[i]) w = i;
                    end
                    m_owner[k] = w;
                    m_last[k]  = w;
                    m_held[k]  = 1;
                end
            end else begin
                g = m_owner[k];
                if (!req[g]) m_owner[k] = -1;
                else if (mh > 0 && m_held[k] >= mh && !lock[g] &&
                         (req & ~(N'(1) << g)) != 0) m_owner[k] = -1;
                else m_held[k] = m_held[k] + 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        nres = 1'b0;
        req  = '0;
        lock = '0;
        rnw  = '1;
        model_reset();
        @(negedge clk);
        nres = 1'b1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < NCFG; k++) begin
            n_checks++;
            if (gnt_o[k] !== 3'b000 || busy_o[k] !== 1'b0 || idx_o[k] !== 3'd0 ||
                a_o[k] !== 16'h0000 || rnw_o[k] !== 1'b1 || d_o[k] !== 8'h00)
                $display("FAIL reset cfg%0d: gnt=%b busy=%b idx=%0d a=%h rnw=%b d=%h, want 000 0 0 0000 1 00",
                         k, gnt_o[k], busy_o[k], idx_o[k], a_o[k], rnw_o[k], d_o[k]);
            else n_pass++;
        end
    endtask

    task automatic test_fixed_handover();
        apply_reset();
        req = 3'b110;
        tick();
        n_checks++;
        if (gnt_o[0] !== 3'b010 || a_o[0] !== 16'hB1B1 || idx_o[0] !== 3'd1)
            $display("FAIL fixed_grant: gnt=%b a=%h idx=%0d, want 010 b1b1 1", gnt_o[0], a_o[0], idx_o[0]);
        else n_pass++;
        tick();
        n_checks++;
        if (gnt_o[0] !== 3'b010) $display("FAIL fixed_keep: gnt=%b, want 010", gnt_o[0]);
        else n_pass++;
        @(negedge clk);
        req = 3'b100;
        tick();
        n_checks++;
        if (gnt_o[0] !== 3'b000 || a_o[0] !== 16'h0000 || rnw_o[0] !== 1'b1 || busy_o[0] !== 1'b0)
            $display("FAIL fixed_idle_gap: gnt=%b a=%h rnw=%b busy=%b, want 000 0000 1 0",
                     gnt_o[0], a_o[0], rnw_o[0], busy_o[0]);
        else n_pass++;
        tick();
        n_checks++;
        if (gnt_o[0] !== 3'b100 || a_o[0] !== 16'hC2C2 || d_o[0] !== 8'h7C)
            $display("FAIL fixed_next: gnt=%b a=%h d=%h, want 100 c2c2 7c", gnt_o[0], a_o[0], d_o[0]);
        else n_pass++;
    endtask

    task automatic test_rr_order();
        int order [4] = '{0, 1, 2, 0};
        logic [N-1:0] eg;
        apply_reset();
        for (int j = 0; j < 4; j++) begin
            eg = N'(1) << order[j];
            @(negedge clk);
            req = 3'b111;
            for (int c = 0; c < 2; c++) begin
                tick();
                n_checks++;
                if (gnt_o[1] !== eg) $display("FAIL rr_order step%0d cyc%0d: gnt=%b, want %b", j, c, gnt_o[1], eg);
                else n_pass++;
            end
            @(negedge clk);
            req = 3'b111 & ~eg;
            tick();
            n_checks++;
            if (gnt_o[1] !== 3'b000) $display("FAIL rr_gap step%0d: gnt=%b, want 000", j, gnt_o[1]);
            else n_pass++;
        end
    endtask

    task automatic test_hold(input logic [N-1:0] lk);
        apply_reset();
        lock = lk;
        req  = 3'b001;
        tick();
        tick();
        @(negedge clk);
        req = 3'b101;
        tick();
        tick();
        for (int k = 0; k < NCFG; k++) begin
            n_checks++;
            if (gnt_o[k] !== 3'b001) $display("FAIL hold_4th_cycle cfg%0d: gnt=%b, want 001", k, gnt_o[k]);
            else n_pass++;
        end
        tick();
        for (int k = 0; k < NCFG; k++) begin
            logic [N-1:0] eg;
            eg = (k >= 2 && lk == 3'b000) ? 3'b000 : 3'b001;
            n_checks++;
            if (gnt_o[k] !== eg) $display("FAIL hold_expiry lock=%b cfg%0d: gnt=%b, want %b", lk, k, gnt_o[k], eg);
            else n_pass++;
        end
        tick();
        for (int k = 0; k < NCFG; k++) begin
            logic [N-1:0] eg;
            eg = (k == 3 && lk == 3'b000) ? 3'b100 : 3'b001;
            n_checks++;
            if (gnt_o[k] !== eg) $display("FAIL hold_regrant lock=%b cfg%0d: gnt=%b, want %b", lk, k, gnt_o[k], eg);
            else n_pass++;
        end
        if (lk != 3'b000) begin
            @(negedge clk);
            req = 3'b100;
            tick();
            tick();
            for (int k = 0; k < NCFG; k++) begin
                n_checks++;
                if (gnt_o[k] !== 3'b100) $display("FAIL lock_release cfg%0d: gnt=%b, want 100", k, gnt_o[k]);
                else n_pass++;
            end
        end
        lock = '0;
    endtask

    task automatic test_reset_mid_grant();
        apply_reset();
        rnw = 3'b101;
        req = 3'b010;
        tick();
        n_checks++;
        if (gnt_o[0] !== 3'b010 || rnw_o[0] !== 1'b0)
            $display("FAIL midrst_write: gnt=%b rnw=%b, want 010 0", gnt_o[0], rnw_o[0]);
        else n_pass++;
        #2;
        nres = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < NCFG; k++) begin
            n_checks++;
            if (gnt_o[k] !== 3'b000 || rnw_o[k] !== 1'b1 || busy_o[k] !== 1'b0)
                $display("FAIL midrst_async cfg%0d: gnt=%b rnw=%b busy=%b, want 000 1 0",
                         k, gnt_o[k], rnw_o[k], busy_o[k]);
            else n_pass++;
        end
        @(posedge clk);
        #1;
        nres = 1'b1;
        #1;
        n_checks++;
        if (gnt_o[0] !== 3'b000) $display("FAIL midrst_no_early: gnt=%b, want 000", gnt_o[0]);
        else n_pass++;
        tick();
        n_checks++;
        if (gnt_o[0] !== 3'b010) $display("FAIL midrst_regrant: gnt=%b, want 010", gnt_o[0]);
        else n_pass++;
        rnw = '1;
    endtask

    task automatic test_idle();
        apply_reset();
        for (int c = 0; c < 10; c++) begin
            tick();
            for (int k = 0; k < NCFG; k++) begin
                n_checks++;
                if (busy_o[k] !== 1'b0 || a_o[k] !== 16'h0000 || rnw_o[k] !== 1'b1)
                    $display("FAIL idle cyc%0d cfg%0d: busy=%b a=%h rnw=%b, want 0 0000 1",
                             c, k, busy_o[k], a_o[k], rnw_o[k]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        logic [N-1:0]  eg;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic          er;
        int            o;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) if ($urandom_range(3) == 0) req[i] = ~req[i];
            lock = ($urandom_range(3) == 0) ? 3'($urandom) : 3'b000;
            a    = 48'({$urandom, $urandom});
            d    = 24'($urandom);
            rnw  = 3'($urandom);
            tick();
            for (int k = 0; k < NCFG; k++) begin
                o = m_owner[k];
                if (o < 0) begin
                    eg = '0; ea = '0; ed = '0; er = 1'b1;
                end else begin
                    eg = N'(1) << o;
                    ea = a[o*AW +: AW];
                    ed = d[o*DW +: DW];
                    er = rnw[o];
                end
                n_checks++;
                if (gnt_o[k] !== eg || busy_o[k] !== (o >= 0) || a_o[k] !== ea ||
                    d_o[k] !== ed || rnw_o[k] !== er || (o >= 0 && idx_o[k] !== 3'(o)))
                    $display("FAIL random cyc%0d cfg%0d: gnt=%b idx=%0d a=%h d=%h rnw=%b, want gnt=%b idx=%0d a=%h d=%h rnw=%b",
                             c, k, gnt_o[k], idx_o[k], a_o[k], d_o[k], rnw_o[k], eg, o, ea, ed, er);
                else n_pass++;
            end
        end
    endtask

    initial begin
        nres = 1'b0;
        req  = '0;
        lock = '0;
        rnw  = '1;
        a    = {16'hC2C2, 16'hB1B1, 16'hA0A0};
        d    = {8'h7C, 8'h6B, 8'h5A};
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_fixed_handover();
        test_rr_order();
        test_hold(3'b000);
        test_hold(3'b001);
        test_reset_mid_grant();
        test_idle();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cpumc_arbiter.md
# cpumc_arbiter

Parametrised arbiter for the CPU memory-controller bus. It replaces the fixed two-way `hci_active` multiplex between the rp2a03 and the hci block with an N-master arbiter. Masters include the CPU, the debug host and future DMA or loader engines. The arbiter registers a one-hot grant, supports fixed-priority or round-robin mode, optional bus locking and a bounded hold time, and drives the single shared `cpumc_a` / `cpumc_r_nw` / `cpumc_din` bus seen by cart, wram and ppu.

## Interface
- `NUM_MASTERS`, default 3: number of requesters, 2..8.
- `ADDR_W`, default 16: address width.
- `DATA_W`, default 8: write-data width.
- `RR_MODE`, default 0: 0 = fixed priority (index 0 highest); 1 = round-robin.
- `MAX_HOLD`, default 0: maximum consecutive granted cycles while another master waits. 0 = unlimited.
- `clk_in`  in  1: system clock, 100 MHz. The only clock.
- `nres_in`  in  1: reset, asynchronous assert, active-low.
- `req_in`  in  NUM_MASTERS: bus request, one bit per master, level-sensitive.
- `lock_in`  in  NUM_MASTERS: master holds the bus past `MAX_HOLD`. Only meaningful while granted.
- `a_in`  in  NUM_MASTERS*ADDR_W: master addresses, master i at bits [i*ADDR_W +: ADDR_W].
- `r_nw_in`  in  NUM_MASTERS: master read/not-write.
- `d_in`  in  NUM_MASTERS*DATA_W: master write data.
- `gnt_out`  out  NUM_MASTERS: registered one-hot grant (all-zero = bus idle). Doubles as each master's rdy.
- `gnt_idx_out`  out  3: index of current owner; valid only when `busy_out` = 1.
- `busy_out`  out  1: |`gnt_out`.
- `a_out`  out  ADDR_W: shared bus address.
- `r_nw_out`  out  1: shared bus read/not-write.
- `d_out`  out  DATA_W: shared bus write data.

## Operation
- States:
  - IDLE: no grant.
  - OWNED: exactly one `gnt_out` bit set.
- IDLE:
  - If `req_in` ≠ 0, select a winner and set its grant bit at the next edge.
  - Fixed mode: lowest index wins.
  - RR mode: first requester found searching upward (with wrap) from `last`+1. `last` = most recently granted index.
- OWNED, owner g: the owner keeps the bus while `req_in[g]` = 1, except on hold expiry.
- Release: if `req_in[g]` = 0, next state is IDLE. There is always one idle cycle between owners, so there are no back-to-back handovers.
- Hold counter:
  - Clears on grant.
  - Increments each OWNED cycle and saturates at `MAX_HOLD`.
  - Expiry: if `MAX_HOLD` > 0, counter = `MAX_HOLD`, `lock_in[g]` = 0, and any other `req_in` bit is set, the owner is revoked and next state is IDLE.
  - A revoked master that still requests competes normally. In RR mode it ranks last.
- Bus mux, combinational from the registered grant:
  - `a_out`, `r_nw_out` and `d_out` come from the owner's slice.
  - IDLE: `a_out` = 0, `r_nw_out` = 1, `d_out` = 0. No write strobe is ever driven while the bus is idle.
- `last` updates only when a grant is issued.
- Request bits for indices ≥ `NUM_MASTERS` do not exist. `gnt_idx_out` is zero-extended.

## Timing
- Reset (async, `nres_in` low):
  - `gnt_out` = 0, `busy_out` = 0, `gnt_idx_out` = 0.
  - `a_out` = 0, `r_nw_out` = 1, `d_out` = 0.
  - Hold counter = 0; `last` = `NUM_MASTERS`-1, so master 0 wins first in RR mode.
  - Deassertion takes effect at the first following edge.
- Reset mid-grant: grant drops immediately and asynchronously. A pending master is granted no earlier than 1 cycle after release.
- Grant latency: request visible at edge n while IDLE → grant at edge n+1.
- Release latency: `req_in[g]` low at edge n → `gnt_out` = 0 at n+1. The next owner is granted at n+2.
- Expiry and release in the same cycle: treated as release, with identical outcome.
- Simultaneous requests in IDLE: exactly one winner per the mode rule. The losers remain pending with no loss.
- `MAX_HOLD` = 0, or a single requester: an owner is never revoked.
- Masters must hold `a_in`/`r_nw_in`/`d_in` stable while granted. The arbiter does not register them.

## Test plan
- Reset then `req_in`=3'b110 (fixed) → `gnt_out`=3'b010 one cycle later, `a_out` = master1 address. On release, 1 idle cycle, then `gnt_out`=3'b100.
- RR mode, `req_in`=3'b111 held, each owner drops req after 2 cycles → grant order 0,1,2,0. Each owner held 2 cycles, separated by 1 idle cycle.
- `MAX_HOLD`=4, master 0 requests continuously, master 2 requests at cycle 2 → master 0 revoked after 4 owned cycles, idle 1 cycle. Master 2 is granted in RR mode, and master 0 is re-granted in fixed mode.
- Same as the previous scenario with `lock_in[0]`=1 → master 0 is never revoked. Master 2 is granted only after master 0 drops req.
- Master 1 writing (`r_nw_in[1]`=0) and `nres_in` pulled low mid-grant → `gnt_out`=0 and `r_nw_out`=1 within the same cycle, with no edge needed. After release, re-grant takes ≥1 cycle.
- IDLE with `req_in`=0 for 10 cycles → `a_out`=0, `r_nw_out`=1, `busy_out`=0 throughout.
